// File: rtl/hdmi_pkg.sv
// rtl/hdmi_pkg.sv - shared TMDS constants, alignment states and helpers
package hdmi_pkg;

  localparam int TMDS_W = 10;

  localparam logic [TMDS_W-1:0] TOK_C00 = 10'h354;
  localparam logic [TMDS_W-1:0] TOK_C01 = 10'h0AB;
  localparam logic [TMDS_W-1:0] TOK_C10 = 10'h154;
  localparam logic [TMDS_W-1:0] TOK_C11 = 10'h2AB;

  localparam logic [3:0] MAX_SHIFT = 4'd9;

  typedef enum logic {
    ST_SEARCH = 1'b0,
    ST_LOCKED = 1'b1
  } align_state_t;

  // Offsets cycle 0..9 so a search sweeps every bit position of the word.
  function automatic logic [3:0] next_shift(input logic [3:0] shift);
    return (shift == MAX_SHIFT) ? 4'd0 : shift + 4'd1;
  endfunction

endpackage

// File: rtl/hdmi_ctrl_detect.sv
// rtl/hdmi_ctrl_detect.sv - combinational TMDS control-token detector
module hdmi_ctrl_detect
  import hdmi_pkg::*;
(
  input  logic [TMDS_W-1:0] word,
  output logic              is_ctrl,
  output logic [1:0]        ctrl
);

  always_comb begin
    is_ctrl = 1'b1;
    ctrl    = 2'b00;
    case (word)
      TOK_C00: ctrl = 2'b00;
      TOK_C01: ctrl = 2'b01;
      TOK_C10: ctrl = 2'b10;
      TOK_C11: ctrl = 2'b11;
      default: is_ctrl = 1'b0;
    endcase
  end

endmodule

// File: rtl/hdmi_word_align.sv
// rtl/hdmi_word_align.sv - TMDS word-boundary hunter and aligner for one lane
module hdmi_word_align
  import hdmi_pkg::*;
#(
  parameter int LOCK_COUNT = 8,
  parameter int DWELL      = 16384,
  parameter int MISS_LIMIT = 8192,
  parameter int CNTW       = 15
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_ce,
  input  logic [TMDS_W-1:0] i_raw,
  input  logic              i_resync,
  output logic              o_valid,
  output logic [TMDS_W-1:0] o_word,
  output logic              o_is_ctrl,
  output logic [1:0]        o_ctrl,
  output logic              o_locked,
  output logic [3:0]        o_shift
);

  localparam logic [CNTW-1:0] LOCK_TERM  = CNTW'(LOCK_COUNT);
  localparam logic [CNTW-1:0] DWELL_TERM = CNTW'(DWELL - 1);
  localparam logic [CNTW-1:0] MISS_TERM  = CNTW'(MISS_LIMIT);
  localparam logic [CNTW-1:0] CNT_ONE    = CNTW'(1);

  align_state_t      state;
  logic [TMDS_W-1:0] prev_raw;
  logic [CNTW-1:0]   match_cnt;
  logic [CNTW-1:0]   dwell_cnt;
  logic [CNTW-1:0]   miss_cnt;

  logic [2*TMDS_W-1:0] window;
  logic [2*TMDS_W-1:0] shifted;
  logic [TMDS_W-1:0]   slice;
  logic                slice_is_ctrl;
  logic [1:0]          slice_ctrl;
  logic [CNTW-1:0]     match_next;
  logic [CNTW-1:0]     miss_next;

  // Offset 0 selects the previous raw word; larger offsets take later bits.
  assign window  = {prev_raw, i_raw};
  assign shifted = window << o_shift;
  assign slice   = shifted[2*TMDS_W-1 -: TMDS_W];

  hdmi_ctrl_detect u_detect (
    .word    (slice),
    .is_ctrl (slice_is_ctrl),
    .ctrl    (slice_ctrl)
  );

  assign match_next = slice_is_ctrl ? match_cnt + CNT_ONE : '0;
  assign miss_next  = slice_is_ctrl ? '0 : miss_cnt + CNT_ONE;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state     <= ST_SEARCH;
      prev_raw  <= '0;
      match_cnt <= '0;
      dwell_cnt <= '0;
      miss_cnt  <= '0;
      o_valid   <= 1'b0;
      o_word    <= '0;
      o_is_ctrl <= 1'b0;
      o_ctrl    <= 2'b00;
      o_locked  <= 1'b0;
      o_shift   <= 4'd0;
    end else begin
      if (i_ce) begin
        prev_raw  <= i_raw;
        o_valid   <= 1'b1;
        o_word    <= slice;
        o_is_ctrl <= slice_is_ctrl;
        o_ctrl    <= slice_ctrl;
      end else begin
        o_valid <= 1'b0;
      end

      // Resync wins over any lock or slip decided on the same edge.
      if (i_resync) begin
        state     <= ST_SEARCH;
        o_locked  <= 1'b0;
        match_cnt <= '0;
        dwell_cnt <= '0;
        miss_cnt  <= '0;
      end else if (i_ce) begin
        if (state == ST_SEARCH) begin
          if (match_next == LOCK_TERM) begin
            state     <= ST_LOCKED;
            o_locked  <= 1'b1;
            match_cnt <= '0;
            dwell_cnt <= '0;
            miss_cnt  <= '0;
          end else if (dwell_cnt == DWELL_TERM) begin
            o_shift   <= next_shift(o_shift);
            match_cnt <= '0;
            dwell_cnt <= '0;
          end else begin
            match_cnt <= match_next;
            dwell_cnt <= dwell_cnt + CNT_ONE;
          end
        end else begin
          // Losing lock keeps o_shift so the hunt restarts at the last good offset.
          if (miss_next == MISS_TERM) begin
            state     <= ST_SEARCH;
            o_locked  <= 1'b0;
            match_cnt <= '0;
            dwell_cnt <= '0;
            miss_cnt  <= '0;
          end else begin
            miss_cnt <= miss_next;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_hdmi_word_align.sv
// tb/tb_hdmi_word_align.sv - randomized self-checking bench for hdmi_word_align
module tb_hdmi_word_align;

  localparam int LOCKN  = 8;
  localparam int DWELLN = 32;
  localparam int MISSN  = 48;

  logic       clk;
  logic       rst_n;
  logic       ce;
  logic [9:0] raw;
  logic       resync;
  logic       valid;
  logic [9:0] word;
  logic       is_ctrl;
  logic [1:0] ctrl;
  logic       locked;
  logic [3:0] shift;

  int total = 0;
  int bad   = 0;

  int tokens[4] = '{'h354, 'h0AB, 'h154, 'h2AB};

  int m_prev, m_shift, m_match, m_dwell, m_miss;
  bit m_locked;
  int e_valid, e_word, e_isc, e_ctrl;
  int seq[$];

  hdmi_word_align #(
    .LOCK_COUNT (LOCKN),
    .DWELL      (DWELLN),
    .MISS_LIMIT (MISSN),
    .CNTW       (15)
  ) dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .i_ce      (ce),
    .i_raw     (raw),
    .i_resync  (resync),
    .o_valid   (valid),
    .o_word    (word),
    .o_is_ctrl (is_ctrl),
    .o_ctrl    (ctrl),
    .o_locked  (locked),
    .o_shift   (shift)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_prev = 0; m_shift = 0; m_match = 0; m_dwell = 0; m_miss = 0; m_locked = 0;
    e_valid = 0; e_word = 0; e_isc = 0; e_ctrl = 0;
  endtask

  // Reference: slice the 20-bit window arithmetically, classify by token table.
  task automatic model_edge(input bit c, input int r, input bit rs);
    int win, s, code;
    bit tok;
    win  = m_prev * 1024 + r;
    s    = (win >> (10 - m_shift)) % 1024;
    tok  = 0;
    code = 0;
    for (int k = 0; k < 4; k++) if (s == tokens[k]) begin tok = 1; code = k; end
    if (c) begin
      e_valid = 1; e_word = s; e_isc = tok; e_ctrl = tok ? code : 0; m_prev = r;
    end else begin
      e_valid = 0;
    end
    if (rs) begin
      m_locked = 0; m_match = 0; m_dwell = 0; m_miss = 0;
    end else if (c) begin
      if (!m_locked) begin
        m_match = tok ? m_match + 1 : 0;
        if (m_match == LOCKN) begin
          m_locked = 1; m_miss = 0; m_match = 0; m_dwell = 0;
        end else if (m_dwell == DWELLN - 1) begin
          m_shift = (m_shift + 1) % 10; m_match = 0; m_dwell = 0;
        end else begin
          m_dwell++;
        end
      end else begin
        m_miss = tok ? 0 : m_miss + 1;
        if (m_miss == MISSN) begin
          m_locked = 0; m_miss = 0; m_match = 0; m_dwell = 0;
        end
      end
    end
  endtask

  task automatic step(input bit c, input int r, input bit rs);
    model_edge(c, r, rs);
    ce = c; raw = 10'(r); resync = rs;
    @(posedge clk);
    #1;
    check("valid",   32'(valid),   32'(e_valid));
    check("word",    32'(word),    32'(e_word));
    check("is_ctrl", 32'(is_ctrl), 32'(e_isc));
    check("ctrl",    32'(ctrl),    32'(e_ctrl));
    check("locked",  32'(locked),  32'(m_locked));
    check("shift",   32'(shift),   32'(m_shift));
    resync = 1'b0;
  endtask

  // Feed an aligned word sequence delayed by d bits across raw word boundaries.
  task automatic feed(input int s[$], input int d);
    int p;
    p = 0;
    foreach (s[n]) begin
      step(1'b1, ((p * 1024 + s[n]) >> d) % 1024, 1'b0);
      p = s[n];
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; ce = 1'b0; raw = '0; resync = 1'b0;
    model_reset();
    #2;
    check("rst_valid",  32'(valid),  0);
    check("rst_word",   32'(word),   0);
    check("rst_locked", 32'(locked), 0);
    check("rst_shift",  32'(shift),  0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #1;
    do_reset();

    // Aligned control tokens at offset 0
    seq.delete();
    repeat (8) seq.push_back('h354);
    repeat (6) seq.push_back('h1F0);
    feed(seq, 0);
    check("s1_locked", 32'(locked), 1);
    check("s1_shift",  32'(shift),  0);

    // Tokens 0AB delayed by 3 bits among data words
    do_reset();
    seq.delete();
    repeat (5) begin
      repeat (20) seq.push_back('h0AB);
      repeat (10) seq.push_back('h1F0);
    end
    feed(seq, 3);
    check("s2_locked", 32'(locked), 1);
    check("s2_shift",  32'(shift),  3);

    // Random data only: offset sweeps and wraps
    do_reset();
    seq.delete();
    repeat (100) seq.push_back(int'($urandom_range(0, 1023)));
    feed(seq, 0);
    check("s3_shift_mid", 32'(shift), 3);
    seq.delete();
    repeat (230) seq.push_back(int'($urandom_range(0, 1023)));
    feed(seq, 0);
    check("s3_shift_wrap", 32'(shift),  0);
    check("s3_locked",     32'(locked), 0);

    // Lock at offset 5, lose tokens, relock without slipping
    do_reset();
    seq.delete();
    repeat (160) seq.push_back(int'($urandom_range(0, 1023)));
    repeat (40) seq.push_back('h354);
    repeat (60) seq.push_back('h1F0);
    repeat (20) seq.push_back('h354);
    begin
      int p;
      p = 0;
      foreach (seq[n]) begin
        step(1'b1, ((p * 1024 + seq[n]) >> 5) % 1024, 1'b0);
        p = seq[n];
        if (n == 199) check("s4_lock1",  32'(locked), 1);
        if (n == 259) check("s4_drop",   32'(locked), 0);
        if (n == 259) check("s4_shift5", 32'(shift),  5);
      end
    end
    check("s4_relock", 32'(locked), 1);
    check("s4_shift",  32'(shift),  5);

    // Aligned tokens with ce on alternate cycles; resync while ce is low
    do_reset();
    for (int n = 0; n < 14; n++) begin
      step(1'b1, (n < 8) ? 'h354 : 'h1F0, 1'b0);
      step(1'b0, int'($urandom_range(0, 1023)), 1'b0);
    end
    check("s5_locked", 32'(locked), 1);
    step(1'b0, 'h354, 1'b1);
    check("s5_resync", 32'(locked), 0);

    // Resync on the lock-achieving word, then relock, then async reset
    do_reset();
    for (int n = 0; n < 8; n++) step(1'b1, 'h354, 1'b0);
    step(1'b1, 'h354, 1'b1);
    check("s6_blocked", 32'(locked), 0);
    for (int n = 0; n < 8; n++) step(1'b1, 'h354, 1'b0);
    check("s6_relock", 32'(locked), 1);
    rst_n = 1'b0;
    #2;
    check("s6_ar_valid",   32'(valid),   0);
    check("s6_ar_word",    32'(word),    0);
    check("s6_ar_is_ctrl", 32'(is_ctrl), 0);
    check("s6_ar_ctrl",    32'(ctrl),    0);
    check("s6_ar_locked",  32'(locked),  0);
    check("s6_ar_shift",   32'(shift),   0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1'b1, 'h1F0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
